bf_mem_arbiter: RTL

Single-owner arbiter that shares one external byte-wide memory port between three requesters of the Brainfuck CPU top level: host loader, CPU data port (cell read/write) and CPU instruction-fetch port. It sits between the bfCPU core/loader and the memory interface behind tt_um_bfcpu. It serialises accesses with one outstanding transaction, performs a req/ready/rvalid handshake to memory, and returns a one-cycle ack per requester.

---
 rtl/bf_mem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/bf_mem_arbiter.sv
// rtl/bf_mem_arbiter.sv - single-owner memory arbiter for host/data/fetch ports (optional ARB_RR_EN)
module bf_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    input  logic              dat_req,
    input  logic              dat_we,
    input  logic [ADDR_W-1:0] dat_addr,
    input  logic [DATA_W-1:0] dat_wdata,
    output logic              dat_ack,
    input  logic              ins_req,
    input  logic [ADDR_W-1:0] ins_addr,
    output logic              ins_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        owner;      // one-hot: [0] host, [1] data, [2] fetch
    logic [2:0]        grant;
    logic              any_req;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req = host_req | dat_req | ins_req;

`ifdef ARB_RR_EN
    logic rr_ptr;              // 0: data wins a tie next, 1: fetch wins a tie next

    // Pointer moves to the other CPU port whenever a CPU port is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (state == IDLE) begin
            if (grant[1]) begin
                rr_ptr <= 1'b1;
            end else if (grant[2]) begin
                rr_ptr <= 1'b0;
            end
        end
    end
`endif

    // Winner selection: host always first, then data vs fetch
    always_comb begin
        grant = 3'b000;
        if (host_req) begin
            grant = 3'b001;
        end else if (dat_req && ins_req) begin
`ifdef ARB_RR_EN
            grant = rr_ptr ? 3'b100 : 3'b010;
`else
            grant = 3'b010;
`endif
        end else if (dat_req) begin
            grant = 3'b010;
        end else if (ins_req) begin
            grant = 3'b100;
        end
    end

    // Request fields of the winning port
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (grant[0]) begin
            sel_we    = host_we;
            sel_addr  = host_addr;
            sel_wdata = host_wdata;
        end else if (grant[1]) begin
            sel_we    = dat_we;
            sel_addr  = dat_addr;
            sel_wdata = dat_wdata;
        end else if (grant[2]) begin
            sel_addr  = ins_addr;
        end
    end

    // State register; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        busy      = 1'b1;
        host_ack  = 1'b0;
        dat_ack   = 1'b0;
        ins_ack   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nxt = mem_we ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                host_ack  = owner[0];
                dat_ack   = owner[1];
                ins_ack   = owner[2];
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the winner's request on grant and capture read data in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= 3'b000;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner     <= grant;
                mem_we    <= sel_we;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
            end
            if (state == WAIT && mem_rvalid) begin
                rdata <= mem_rdata;
            end
        end
    end

endmodule
